// File: rtl/turbo_len_pkg.sv
// turbo_len_pkg
// Shared definitions for the turbo interleaver length/enable generator:
//   - default parameter values (ID_W_DEF, LEN_W_DEF, LANES_DEF)
//   - FSM state encoding
//   - clog2 helper and the default length table len_of_id()
// Optional build macro used by the files that import this package:
//   TURBO_LEN_PROG_EN - makes the length table writable through cfg_* ports.
package turbo_len_pkg;

  localparam int ID_W_DEF  = 6;
  localparam int LEN_W_DEF = 13;
  localparam int LANES_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_RUN    = 2'd2,
    S_FIN    = 2'd3
  } state_t;

  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Default table: 64 positions per step of link ID, 64..4096 for 6-bit IDs.
  function automatic int unsigned len_of_id(input int unsigned id);
    return 64 * (id + 1);
  endfunction

endpackage

// File: rtl/turbo_len_tbl.sv
// turbo_len_tbl
// Link-ID to message-length table with a one-cycle registered read.
// Build macro: TURBO_LEN_PROG_EN - table becomes a register file loaded with
// the default contents on reset and writable via cfg_*; otherwise a constant ROM.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rd_en, rd_addr      read request; rd_data updates on the next edge, else holds
//   rd_data             registered table entry
//   cfg_we/addr/len     table write port (TURBO_LEN_PROG_EN only)
module turbo_len_tbl
  import turbo_len_pkg::*;
#(
  parameter int ID_W  = ID_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  input  logic [ID_W-1:0]  rd_addr,
`ifdef TURBO_LEN_PROG_EN
  input  logic             cfg_we,
  input  logic [ID_W-1:0]  cfg_addr,
  input  logic [LEN_W-1:0] cfg_len,
`endif
  output logic [LEN_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ID_W;

`ifdef TURBO_LEN_PROG_EN
  logic [LEN_W-1:0] mem [DEPTH];

  // Read samples the array before any same-edge write lands, so a write
  // racing a read of the same entry yields the old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= LEN_W'(len_of_id(i));
      end
      rd_data <= '0;
    end else begin
      if (cfg_we) mem[cfg_addr] <= cfg_len;
      if (rd_en)  rd_data <= mem[rd_addr];
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= LEN_W'(len_of_id(32'(rd_addr)));
    end
  end
`endif

endmodule

// File: rtl/turbo_len_gen.sv
// turbo_len_gen
// Maps a link ID to a message length and streams a LANES-wide enable mask per
// beat until m_len positions are covered, with backpressure and busy/done.
// Build macro: TURBO_LEN_PROG_EN - exposes the cfg_* table write port.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_enable, link_id       one-cycle frame request
//   en_ready                 downstream accepts current beat
//   enable, en_valid, en_last  beat mask / valid / final-beat flag
//   m_len                    length of current (or last) frame
//   busy, done, id_err       frame in progress / completion pulse / dropped request
//   cfg_we, cfg_addr, cfg_len  table write (TURBO_LEN_PROG_EN only)
// All outputs are registered.
//
// state  | meaning
// IDLE   | waiting for id_enable; table read issued on request
// LOOKUP | table entry available; load m_len, beat count and first beat
// RUN    | presenting beats; advance on en_valid & en_ready
// FIN    | done pulse, then back to IDLE
module turbo_len_gen
  import turbo_len_pkg::*;
#(
  parameter int ID_W  = ID_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int LANES = LANES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_enable,
  input  logic [ID_W-1:0]  link_id,
  input  logic             en_ready,
`ifdef TURBO_LEN_PROG_EN
  input  logic             cfg_we,
  input  logic [ID_W-1:0]  cfg_addr,
  input  logic [LEN_W-1:0] cfg_len,
`endif
  output logic [LANES-1:0] enable,
  output logic             en_valid,
  output logic             en_last,
  output logic [LEN_W-1:0] m_len,
  output logic             busy,
  output logic             done,
  output logic             id_err
);

  localparam int LB    = clog2(LANES);
  localparam int CNT_W = LEN_W - LB + 1;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d, beats_new;
  logic [LANES-1:0] tail_q, tail_d, tail_new, enable_d;
  logic [LEN_W-1:0] tbl_q, rem_new, m_len_d;
  logic [LEN_W:0]   len_round;
  logic             tbl_rd;
  logic             en_valid_d, en_last_d, busy_d, done_d, id_err_d;
  logic             hs;

  assign tbl_rd = (state == S_IDLE) && id_enable;
  assign hs     = en_valid && en_ready;

  turbo_len_tbl #(.ID_W(ID_W), .LEN_W(LEN_W)) u_tbl (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (tbl_rd),
    .rd_addr (link_id),
`ifdef TURBO_LEN_PROG_EN
    .cfg_we  (cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_len (cfg_len),
`endif
    .rd_data (tbl_q)
  );

  // One extra bit so the round-up never wraps at m_len = 2**LEN_W-1.
  assign len_round = {1'b0, tbl_q} + (LEN_W+1)'(LANES - 1);
  assign beats_new = CNT_W'(len_round >> LB);
  assign rem_new   = tbl_q & LEN_W'(LANES - 1);

  // Mask used for the final beat: full when the length is a LANES multiple.
  always_comb begin
    tail_new = '0;
    for (int i = 0; i < LANES; i++) begin
      tail_new[i] = (rem_new == '0) || (LEN_W'(i) < rem_new);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (id_enable) state_d = S_LOOKUP;
      S_LOOKUP: state_d = (tbl_q == '0) ? S_FIN : S_RUN;
      S_RUN:    if (hs && (cnt == CNT_W'(1))) state_d = S_FIN;
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    cnt_d      = cnt;
    tail_d     = tail_q;
    m_len_d    = m_len;
    enable_d   = enable;
    en_last_d  = en_last;
    case (state)
      S_LOOKUP: begin
        m_len_d = tbl_q;
        tail_d  = tail_new;
        cnt_d   = beats_new;
        if (tbl_q == '0) begin
          enable_d  = '0;
          en_last_d = 1'b0;
        end else if (beats_new == CNT_W'(1)) begin
          enable_d  = tail_new;
          en_last_d = 1'b1;
        end else begin
          enable_d  = '1;
          en_last_d = 1'b0;
        end
      end
      S_RUN: begin
        if (hs) begin
          cnt_d = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            enable_d  = '0;
            en_last_d = 1'b0;
          end else if (cnt == CNT_W'(2)) begin
            enable_d  = tail_q;
            en_last_d = 1'b1;
          end else begin
            enable_d  = '1;
            en_last_d = 1'b0;
          end
        end
      end
      default: begin
        enable_d  = '0;
        en_last_d = 1'b0;
      end
    endcase
    en_valid_d = (state_d == S_RUN);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_FIN);
    id_err_d   = id_enable && (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      tail_q   <= '0;
      m_len    <= '0;
      enable   <= '0;
      en_valid <= 1'b0;
      en_last  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      id_err   <= 1'b0;
    end else begin
      cnt      <= cnt_d;
      tail_q   <= tail_d;
      m_len    <= m_len_d;
      enable   <= enable_d;
      en_valid <= en_valid_d;
      en_last  <= en_last_d;
      busy     <= busy_d;
      done     <= done_d;
      id_err   <= id_err_d;
    end
  end

endmodule

// File: tb/tb_turbo_len_gen.sv
// tb_turbo_len_gen
// Scoreboard bench for turbo_len_gen: requests push the expected beat list,
// a negedge monitor pops and compares on each handshake.
// Build macro: TURBO_LEN_PROG_EN - also exercises the cfg_* table write port.
module tb_turbo_len_gen;

  localparam int ID_W  = 6;
  localparam int LEN_W = 13;
  localparam int LANES = 16;

  typedef struct {
    logic [LANES-1:0] en;
    logic             last;
    logic [LEN_W-1:0] mlen;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_enable;
  logic [ID_W-1:0]  link_id;
  logic             en_ready;
  logic [LANES-1:0] enable;
  logic             en_valid, en_last, busy, done, id_err;
  logic [LEN_W-1:0] m_len;
`ifdef TURBO_LEN_PROG_EN
  logic             cfg_we;
  logic [ID_W-1:0]  cfg_addr;
  logic [LEN_W-1:0] cfg_len;
`endif

  turbo_len_gen #(.ID_W(ID_W), .LEN_W(LEN_W), .LANES(LANES)) dut (
    .clk      (clk),
    .rst      (rst),
    .id_enable(id_enable),
    .link_id  (link_id),
    .en_ready (en_ready),
`ifdef TURBO_LEN_PROG_EN
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_len  (cfg_len),
`endif
    .enable   (enable),
    .en_valid (en_valid),
    .en_last  (en_last),
    .m_len    (m_len),
    .busy     (busy),
    .done     (done),
    .id_err   (id_err)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_err    = 0;
  int    done_cnt = 0;
  int    ready_mode = 0;
  int    model_tbl [64];
  beat_t exp_q [$];

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: ceil(L/LANES) beats, last one masked to the L mod LANES low lanes.
  task automatic push_frame(input int len);
    int    nb, rem;
    beat_t b;
    nb  = (len + LANES - 1) / LANES;
    rem = len % LANES;
    for (int k = 0; k < nb; k++) begin
      b.last = (k == nb - 1);
      b.mlen = LEN_W'(len);
      if (b.last && rem != 0) b.en = LANES'((32'd1 << rem) - 1);
      else                    b.en = '1;
      exp_q.push_back(b);
    end
  endtask

  // Ready pattern: 0 always ready, 1 random, 2 repeating 1,0,0,1.
  initial begin
    int pidx;
    logic [3:0] pat;
    pidx = 0;
    pat  = 4'b1001;
    en_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       en_ready = ($urandom_range(0, 3) != 0);
        2:       begin en_ready = pat[3 - pidx]; pidx = (pidx + 1) % 4; end
        default: en_ready = 1'b1;
      endcase
    end
  end

  // Monitor: beat compare, stall stability, done timing.
  initial begin
    logic             prev_stall, exp_done, prev_last;
    logic [LANES-1:0] prev_en;
    beat_t            b;
    prev_stall = 1'b0; exp_done = 1'b0; prev_last = 1'b0; prev_en = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        exp_done   = 1'b0;
      end else begin
        if (exp_done) check_eq("done_after_last", 64'(done), 64'd1);
        if (done) done_cnt++;
        if (prev_stall)
          check_eq("stall_hold", 64'({en_valid, enable, en_last}), 64'({1'b1, prev_en, prev_last}));
        exp_done = 1'b0;
        if (en_valid && en_ready) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_beat", 64'({enable, en_last}), 64'd0);
          end else begin
            b = exp_q.pop_front();
            check_eq("beat", 64'({enable, en_last, m_len}), 64'({b.en, b.last, b.mlen}));
          end
          exp_done = en_last;
        end
        prev_stall = en_valid && !en_ready;
        prev_en    = enable;
        prev_last  = en_last;
      end
    end
  end

  task automatic wait_idle();
    int k;
    for (k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (k == 5000) check_eq("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic start_req(input int id, input int mode);
    @(posedge clk);
    #1;
    ready_mode = mode;
    id_enable  = 1'b1;
    link_id    = ID_W'(id);
    @(posedge clk);
    #1;
    id_enable  = 1'b0;
  endtask

  task automatic run_frame(input int id, input int mode, input bit inject);
    int len, d0, k;
    len = model_tbl[id];
    wait_idle();
    push_frame(len);
    d0 = done_cnt;
    start_req(id, mode);
    @(negedge clk);
    check_eq("busy_latency", 64'({busy, en_valid}), 64'b10);
    @(negedge clk);
    if (len > 0) check_eq("first_beat_latency", 64'(en_valid), 64'd1);
    else         check_eq("zero_len_done", 64'({done, en_valid}), 64'b10);
    if (inject) begin
      @(posedge clk);
      #1;
      id_enable = 1'b1;
      link_id   = ID_W'($urandom_range(0, 63));
      @(posedge clk);
      #1;
      id_enable = 1'b0;
      @(negedge clk);
      check_eq("id_err_pulse", 64'(id_err), 64'd1);
      @(negedge clk);
      check_eq("id_err_clear", 64'(id_err), 64'd0);
    end
    for (k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (done_cnt > d0) break;
    end
    if (k == 5000) check_eq("done_timeout", 64'(done_cnt - d0), 64'd1);
    @(negedge clk);
    check_eq("frame_end", 64'({busy, 7'(exp_q.size()), 8'(done_cnt - d0)}), 64'({1'b0, 7'd0, 8'd1}));
    check_eq("m_len_hold", 64'(m_len), 64'(len));
  endtask

  initial begin
    int d0;
    for (int i = 0; i < 64; i++) model_tbl[i] = 64 * (i + 1);
    rst = 1'b1; id_enable = 1'b0; link_id = '0;
`ifdef TURBO_LEN_PROG_EN
    cfg_we = 1'b0; cfg_addr = '0; cfg_len = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_state", 64'({enable, en_valid, en_last, m_len, busy, done, id_err}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_frame(0, 0, 1'b0);   // 64 -> 4 full beats
    run_frame(63, 0, 1'b0);  // 4096 -> 256 beats
    run_frame(0, 2, 1'b0);   // stalls 1,0,0,1
    run_frame(10, 0, 1'b1);  // request while busy

    // Reset in the middle of a frame.
    wait_idle();
    push_frame(model_tbl[20]);
    start_req(20, 0);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_run", 64'({enable, en_valid, en_last, m_len, busy, done, id_err}), 64'd0);
    exp_q.delete();
    d0 = done_cnt;
    repeat (5) @(negedge clk);
    check_eq("rst_no_done", 64'(done_cnt - d0), 64'd0);
    run_frame(7, 1, 1'b0);

    for (int r = 0; r < 12; r++) begin
      run_frame(int'($urandom_range(0, 63)), int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
    end

`ifdef TURBO_LEN_PROG_EN
    @(posedge clk);
    #1;
    cfg_we = 1'b1; cfg_addr = 6'd5; cfg_len = 13'd37;
    @(posedge clk);
    #1;
    cfg_we = 1'b1; cfg_addr = 6'd9; cfg_len = 13'd0;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    model_tbl[5] = 37;
    model_tbl[9] = 0;
    run_frame(5, 0, 1'b0);   // FFFF, FFFF, 001F last
    run_frame(9, 0, 1'b0);   // zero length: no beats
    run_frame(5, 1, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
